block_reader: RTL and testbench

BLOCK_READER -- requirements
Module: block_reader

---
 rtl/block_reader.sv | 138 +++++++++++++
 tb/tb_block_reader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/block_reader.sv
// 8x8 luma block buffer: converts RGB pixels to level-shifted Y samples,
// collects 64 of them, then drains them in raster order to the DCT stage.
module block_reader #(
  parameter int NPIX = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_en,
  input  logic [7:0]        iR,
  input  logic [7:0]        iG,
  input  logic [7:0]        iB,
  input  logic              out_ready,
  output logic              out_valid,
  output logic signed [7:0] out_data,
  output logic [5:0]        out_idx,
  output logic              out_last,
  output logic              blk_full,
  output logic              overrun
);

  localparam logic [5:0] LAST_IDX = 6'(NPIX - 1);

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  state_t     state_r;
  state_t     state_nx_s;
  logic [5:0] wr_ptr_r;
  logic [5:0] rd_ptr_r;
  logic [7:0] buffer_r [0:63];
  logic       blk_full_r;
  logic       overrun_r;
  logic       wr_fire_s;
  logic       rd_fire_s;
  logic       drop_s;
  logic [7:0] sample_s;

  // Max sum is 255*256+128 = 65408, so 16 bits never overflow.
  function automatic logic [7:0] luma_sample(input logic [7:0] r,
                                             input logic [7:0] g,
                                             input logic [7:0] b);
    logic [15:0] sum;
    logic [7:0]  y;
    sum = 16'(r) * 16'd77 + 16'(g) * 16'd150 + 16'(b) * 16'd29 + 16'd128;
    y   = sum[15:8];
    return {~y[7], y[6:0]};
  endfunction

  assign sample_s  = luma_sample(iR, iG, iB);
  assign wr_fire_s = (state_r == FILL) && read_en;
  assign rd_fire_s = (state_r == DRAIN) && out_ready;
  assign drop_s    = (state_r == DRAIN) && read_en;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= FILL;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state: last write starts a drain, last handshake returns to fill
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      FILL: begin
        if (wr_fire_s && (wr_ptr_r == LAST_IDX)) begin
          state_nx_s = DRAIN;
        end else begin
          state_nx_s = FILL;
        end
      end
      DRAIN: begin
        if (rd_fire_s && (rd_ptr_r == LAST_IDX)) begin
          state_nx_s = FILL;
        end else begin
          state_nx_s = DRAIN;
        end
      end
      default: state_nx_s = FILL;
    endcase
  end

  // Pointers, full pulse and sticky overrun flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r   <= 6'd0;
      rd_ptr_r   <= 6'd0;
      blk_full_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      if (wr_fire_s) begin
        wr_ptr_r <= wr_ptr_r + 6'd1;
      end
      if (rd_fire_s) begin
        rd_ptr_r <= rd_ptr_r + 6'd1;
      end
      blk_full_r <= wr_fire_s && (wr_ptr_r == LAST_IDX);
      overrun_r  <= overrun_r | drop_s;
    end
  end

  // Sample storage needs no reset; only FILL writes reach it
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      buffer_r[wr_ptr_r] <= sample_s;
    end
  end

  // Output decode; data forced to zero in FILL so it never shows stale X
  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'sd0;
    out_idx   = rd_ptr_r;
    out_last  = 1'b0;
    case (state_r)
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = $signed(buffer_r[rd_ptr_r]);
        out_last  = (rd_ptr_r == LAST_IDX);
      end
      FILL: begin
        out_valid = 1'b0;
        out_data  = 8'sd0;
        out_last  = 1'b0;
      end
      default: begin
        out_valid = 1'b0;
        out_data  = 8'sd0;
        out_last  = 1'b0;
      end
    endcase
  end

  assign blk_full = blk_full_r;
  assign overrun  = overrun_r;

endmodule

// File: tb/tb_block_reader.sv
// Self-checking bench for block_reader: directed scenarios with random pixels,
// expected samples computed directly from the luma formula.
module tb_block_reader;

  logic              clk;
  logic              rst;
  logic              read_en;
  logic [7:0]        iR;
  logic [7:0]        iG;
  logic [7:0]        iB;
  logic              out_ready;
  logic              out_valid;
  logic signed [7:0] out_data;
  logic [5:0]        out_idx;
  logic              out_last;
  logic              blk_full;
  logic              overrun;

  int checks;
  int errors;
  int exp_blk [0:63];
  int drain_cycles;

  block_reader #(.NPIX(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .read_en   (read_en),
    .iR        (iR),
    .iG        (iG),
    .iB        (iB),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .blk_full  (blk_full),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_sample(input int r, input int g, input int b);
    int y;
    y = (77 * r + 150 * g + 29 * b + 128) / 256;
    return y - 128;
  endfunction

  // kind 0: white, 1: black then red, 2: random. gaps inserts idle cycles.
  task automatic write_block(input int kind, input bit gaps, input int n);
    int r, g, b;
    for (int k = 0; k < n; k++) begin
      if (gaps && ($urandom_range(3) == 0)) begin
        read_en = 1'b0;
        tick();
        chk("gap_valid", out_valid, 0);
      end
      case (kind)
        0: begin r = 255; g = 255; b = 255; end
        1: begin
          if (k < 32) begin r = 0; g = 0; b = 0; end
          else begin r = 255; g = 0; b = 0; end
        end
        default: begin
          r = $urandom_range(255); g = $urandom_range(255); b = $urandom_range(255);
        end
      endcase
      iR = 8'(r); iG = 8'(g); iB = 8'(b);
      read_en = 1'b1;
      exp_blk[k] = model_sample(r, g, b);
      tick();
      read_en = 1'b0;
      if (k == 63) begin
        chk("full_pulse", blk_full, 1);
        chk("first_valid", out_valid, 1);
        chk("first_idx", out_idx, 0);
      end else begin
        chk("fill_nofull", blk_full, 0);
        chk("fill_valid", out_valid, 0);
        chk("fill_last", out_last, 0);
      end
    end
  endtask

  // mode 0: ready high, 1: toggle 1,0,..., 2: random. ovr_n: read_en on first
  // ovr_n cycles; ovr_last: read_en on the final handshake edge.
  task automatic drain(input int mode, input int ovr_n, input bit ovr_last,
                       output int cycles);
    int  hs;
    int  cyc;
    bit  rdy;
    hs = 0;
    cyc = 0;
    while (hs < 64 && cyc < 2000) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_idx", out_idx, hs);
      chk("drain_data", $signed(out_data), exp_blk[hs]);
      chk("drain_last", out_last, (hs == 63) ? 1 : 0);
      chk("full_once", blk_full, (cyc == 0) ? 1 : 0);
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 2) == 0;
        default: rdy = 1'($urandom_range(1));
      endcase
      out_ready = rdy;
      read_en = (cyc < ovr_n) || (ovr_last && rdy && hs == 63);
      iR = 8'($urandom); iG = 8'($urandom); iB = 8'($urandom);
      tick();
      if (rdy) hs++;
      cyc++;
    end
    read_en = 1'b0;
    out_ready = 1'b0;
    chk("drain_done", hs, 64);
    chk("back_to_fill", out_valid, 0);
    chk("fill_last_low", out_last, 0);
    cycles = cyc;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    read_en = 1'b0;
    out_ready = 1'b0;
    iR = 8'd0; iG = 8'd0; iB = 8'd0;
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_full", blk_full, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_idx", out_idx, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // white block, ready always high: 64 cycles
    write_block(0, 1'b0, 64);
    chk("white_val", exp_blk[0], 127);
    drain(0, 0, 1'b0, drain_cycles);
    chk("white_cycles", drain_cycles, 64);

    // black then pure red
    write_block(1, 1'b0, 64);
    drain(0, 0, 1'b0, drain_cycles);

    // random pixels with read_en gaps, alternating backpressure
    write_block(2, 1'b1, 64);
    drain(1, 0, 1'b0, drain_cycles);
    chk("bp_cycles", drain_cycles, 127);

    // overrun: three dropped pixels, then one on the final handshake edge
    write_block(2, 1'b0, 64);
    chk("ovr_before", overrun, 0);
    drain(1, 3, 1'b1, drain_cycles);
    chk("ovr_set", overrun, 1);
    write_block(2, 1'b1, 64);
    chk("ovr_sticky", overrun, 1);
    drain(2, 0, 1'b0, drain_cycles);
    chk("ovr_sticky2", overrun, 1);

    // mid-fill reset abandons 40 samples and clears overrun
    write_block(2, 1'b0, 40);
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_ovr", overrun, 0);
    chk("mrst_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    write_block(2, 1'b1, 64);
    drain(2, 0, 1'b0, drain_cycles);
    chk("mrst_ovr_end", overrun, 0);

    // mid-drain reset, then a clean block
    write_block(2, 1'b0, 64);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("drst_valid", out_valid, 0);
    chk("drst_idx", out_idx, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    write_block(2, 1'b0, 64);
    drain(0, 0, 1'b0, drain_cycles);
    chk("drst_cycles", drain_cycles, 64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
